dm_hart_ctrl: RTL and testbench

DM_HART_CTRL -- requirements
Module: dm_hart_ctrl

---
 rtl/debug_pkg.sv | 46 ++++
 rtl/dm_abscmd_fsm.sv | 160 ++++++++++++++++
 rtl/dm_hart_ctrl.sv | 131 +++++++++++++
 tb/tb_dm_hart_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants, enums and command decode for the hart debug controller.
// The abstractauto register only exists when DM_ABSTRACT_AUTOEXEC_EN is defined.
package debug_pkg;

    localparam logic [6:0] ADDR_DATA0        = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL    = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS     = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS   = 7'h16;
    localparam logic [6:0] ADDR_COMMAND      = 7'h17;
    localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;

    localparam int CMDTYPE_W = 8;
    localparam int AARSIZE_W = 3;
    localparam int REGNO_W   = 16;

    localparam logic [AARSIZE_W-1:0] AARSIZE_32 = 3'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_ACK} res_state_e;
    typedef enum logic [1:0] {A_IDLE, A_XFER, A_DONE} abs_state_e;

    typedef struct packed {
        logic [CMDTYPE_W-1:0] cmdtype;
        logic [AARSIZE_W-1:0] aarsize;
        logic                 transfer;
        logic                 write;
        logic [REGNO_W-1:0]   regno;
    } acc_cmd_t;

    function automatic acc_cmd_t decode_cmd(input logic [31:0] w);
        acc_cmd_t c;
        c.cmdtype  = w[31:24];
        c.aarsize  = w[22:20];
        c.transfer = w[17];
        c.write    = w[16];
        c.regno    = w[15:0];
        return c;
    endfunction

endpackage

// File: rtl/dm_abscmd_fsm.sv
// Abstract command FSM with the data0 register and cmderr tracking.
// DM_ABSTRACT_AUTOEXEC_EN adds abstractauto.autoexecdata0 and command re-issue.
module dm_abscmd_fsm
    import debug_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        active_i,
    input  logic        core_halted_i,
    input  logic        data0_wr_i,
    input  logic        data0_rd_i,
    input  logic        acs_wr_i,
    input  logic        cmd_wr_i,
    input  logic        auto_wr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] ar_di_i,
    output logic [31:0] data0_o,
    output logic [2:0]  cmderr_o,
    output logic        busy_o,
    output logic        autoexec_o,
    output logic        ar_en_o,
    output logic        ar_wr_o,
    output logic [15:0] ar_ad_o,
    output logic [31:0] ar_do_o
);

    // state  | meaning
    // A_IDLE | accepting commands
    // A_XFER | one-cycle register access on the ar_* port
    // A_DONE | completion cycle, still busy
    abs_state_e         state_q, state_d;
    logic [31:0]        data0_q, data0_d;
    cmderr_e            cmderr_q, cmderr_d;
    logic               wr_q, wr_d;
    logic [REGNO_W-1:0] regno_q, regno_d;
    logic               busy;
    logic               issue;
    logic [31:0]        issue_word;
    acc_cmd_t           cmd;

    assign busy = (state_q != A_IDLE);

`ifdef DM_ABSTRACT_AUTOEXEC_EN
    logic        auto_q;
    logic        auto_pend_q;
    logic [31:0] last_cmd_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            auto_q      <= 1'b0;
            auto_pend_q <= 1'b0;
            last_cmd_q  <= '0;
        end else if (!active_i) begin
            auto_q      <= 1'b0;
            auto_pend_q <= 1'b0;
            last_cmd_q  <= '0;
        end else begin
            if (auto_wr_i) auto_q <= wdata_i[0];
            auto_pend_q <= auto_q && (data0_wr_i || data0_rd_i) && !busy
                           && (cmderr_q == CMDERR_NONE);
            if (cmd_wr_i && !busy && (cmderr_q == CMDERR_NONE)) last_cmd_q <= wdata_i;
        end
    end

    assign autoexec_o = auto_q;

    always_comb begin
        issue      = 1'b0;
        issue_word = wdata_i;
        if (!busy && (cmderr_q == CMDERR_NONE)) begin
            if (cmd_wr_i) begin
                issue = 1'b1;
            end else if (auto_pend_q) begin
                issue      = 1'b1;
                issue_word = last_cmd_q;
            end
        end
    end
`else
    logic unused_auto;
    assign unused_auto = auto_wr_i;
    assign autoexec_o  = 1'b0;

    always_comb begin
        issue      = cmd_wr_i && !busy && (cmderr_q == CMDERR_NONE);
        issue_word = wdata_i;
    end
`endif

    always_comb begin
        state_d  = state_q;
        data0_d  = data0_q;
        cmderr_d = cmderr_q;
        wr_d     = wr_q;
        regno_d  = regno_q;
        cmd      = decode_cmd(issue_word);
        case (state_q)
            A_IDLE: begin
                if (data0_wr_i) data0_d = wdata_i;
                if (acs_wr_i) cmderr_d = cmderr_e'(cmderr_q & ~wdata_i[10:8]);
                if (issue) begin
                    if ((cmd.cmdtype != '0) || (cmd.aarsize != AARSIZE_32)) begin
                        cmderr_d = CMDERR_NOTSUP;
                    end else if (!core_halted_i) begin
                        cmderr_d = CMDERR_HALTRESUME;
                    end else if (!cmd.transfer) begin
                        state_d = A_DONE;
                    end else begin
                        state_d = A_XFER;
                        wr_d    = cmd.write;
                        regno_d = cmd.regno;
                    end
                end
            end
            A_XFER: begin
                if (!wr_q) data0_d = ar_di_i;
                state_d = A_DONE;
            end
            A_DONE:  state_d = A_IDLE;
            default: state_d = A_IDLE;
        endcase
        if (busy && (cmderr_q == CMDERR_NONE)
            && (data0_wr_i || data0_rd_i || acs_wr_i || cmd_wr_i)) begin
            cmderr_d = CMDERR_BUSY;
        end
        // Deactivating the DM drops any in-flight command and clears all state.
        if (!active_i) begin
            state_d  = A_IDLE;
            data0_d  = '0;
            cmderr_d = CMDERR_NONE;
            wr_d     = 1'b0;
            regno_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= A_IDLE;
            data0_q  <= '0;
            cmderr_q <= CMDERR_NONE;
            wr_q     <= 1'b0;
            regno_q  <= '0;
        end else begin
            state_q  <= state_d;
            data0_q  <= data0_d;
            cmderr_q <= cmderr_d;
            wr_q     <= wr_d;
            regno_q  <= regno_d;
        end
    end

    assign data0_o  = data0_q;
    assign cmderr_o = cmderr_q;
    assign busy_o   = busy;
    assign ar_en_o  = active_i && (state_q == A_XFER);
    assign ar_wr_o  = ar_en_o && wr_q;
    assign ar_ad_o  = ar_en_o ? regno_q : '0;
    assign ar_do_o  = active_i ? data0_q : '0;

endmodule

// File: rtl/dm_hart_ctrl.sv
// Debug module hart controller: DMI register decode, halt/resume control.
// DM_ABSTRACT_AUTOEXEC_EN enables abstractauto (handled in dm_abscmd_fsm).
module dm_hart_ctrl
    import debug_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        dmi_en_i,
    input  logic        dmi_wr_i,
    input  logic [6:0]  dmi_addr_i,
    input  logic [31:0] dmi_wdata_i,
    output logic [31:0] dmi_rdata_o,
    output logic        dbg_haltreq_o,
    output logic        dbg_resumereq_o,
    input  logic        core_resumeack_i,
    input  logic        core_running_i,
    input  logic        core_halted_i,
    output logic        dbg_ar_en_o,
    output logic        dbg_ar_wr_o,
    output logic [15:0] dbg_ar_ad_o,
    output logic [31:0] dbg_ar_do_o,
    input  logic [31:0] dbg_ar_di_i
);

    // state  | meaning
    // R_IDLE | no resume in progress
    // R_REQ  | resumereq asserted, waiting for core ack
    // R_ACK  | ack seen, waiting for ack to drop
    res_state_e  rstate_q, rstate_d;
    logic        dmactive_q, dmactive_d;
    logic        haltreq_q, haltreq_d;
    logic        resumeack_q, resumeack_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_en, rd_en, dmc_wr;
    logic [31:0] data0;
    logic [2:0]  cmderr;
    logic        busy, autoexec;
    logic [31:0] rmux;

    assign wr_en  = dmi_en_i && dmi_wr_i;
    assign rd_en  = dmi_en_i && !dmi_wr_i;
    assign dmc_wr = wr_en && (dmi_addr_i == ADDR_DMCONTROL);

    dm_abscmd_fsm u_abscmd (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .active_i      (dmactive_q),
        .core_halted_i (core_halted_i),
        .data0_wr_i    (wr_en && (dmi_addr_i == ADDR_DATA0)),
        .data0_rd_i    (rd_en && (dmi_addr_i == ADDR_DATA0)),
        .acs_wr_i      (wr_en && (dmi_addr_i == ADDR_ABSTRACTCS)),
        .cmd_wr_i      (wr_en && (dmi_addr_i == ADDR_COMMAND)),
        .auto_wr_i     (wr_en && (dmi_addr_i == ADDR_ABSTRACTAUTO)),
        .wdata_i       (dmi_wdata_i),
        .ar_di_i       (dbg_ar_di_i),
        .data0_o       (data0),
        .cmderr_o      (cmderr),
        .busy_o        (busy),
        .autoexec_o    (autoexec),
        .ar_en_o       (dbg_ar_en_o),
        .ar_wr_o       (dbg_ar_wr_o),
        .ar_ad_o       (dbg_ar_ad_o),
        .ar_do_o       (dbg_ar_do_o)
    );

    always_comb begin
        rmux = '0;
        case (dmi_addr_i)
            ADDR_DATA0:        rmux = data0;
            ADDR_DMCONTROL:    rmux = {haltreq_q, 30'd0, dmactive_q};
            ADDR_DMSTATUS:     rmux = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                       core_running_i, core_running_i,
                                       core_halted_i, core_halted_i, 1'b1, 3'd0, 4'd2};
            ADDR_ABSTRACTCS:   rmux = {19'd0, busy, 1'b0, cmderr, 4'd0, 4'd1};
            ADDR_ABSTRACTAUTO: rmux = {31'd0, autoexec};
            default:           rmux = '0;
        endcase
    end

    always_comb begin
        dmactive_d  = dmc_wr ? dmi_wdata_i[0] : dmactive_q;
        haltreq_d   = dmc_wr ? dmi_wdata_i[31] : haltreq_q;
        rstate_d    = rstate_q;
        resumeack_d = resumeack_q;
        rdata_d     = rd_en ? rmux : rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (dmc_wr && dmi_wdata_i[30] && !dmi_wdata_i[31] && core_halted_i) begin
                    rstate_d    = R_REQ;
                    resumeack_d = 1'b0;
                end
            end
            R_REQ: begin
                if (core_resumeack_i) begin
                    rstate_d    = R_ACK;
                    resumeack_d = 1'b1;
                end
            end
            R_ACK:   if (!core_resumeack_i) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
        // Using the new dmactive lets one write set dmactive and haltreq together.
        if (!dmactive_d) begin
            haltreq_d   = 1'b0;
            rstate_d    = R_IDLE;
            resumeack_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            rstate_q    <= R_IDLE;
            resumeack_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            dmactive_q  <= dmactive_d;
            haltreq_q   <= haltreq_d;
            rstate_q    <= rstate_d;
            resumeack_q <= resumeack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign dmi_rdata_o     = rdata_q;
    assign dbg_haltreq_o   = haltreq_q && dmactive_q;
    assign dbg_resumereq_o = dmactive_q && (rstate_q == R_REQ);

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Directed scoreboard bench for dm_hart_ctrl: DMI reads and abstract accesses
// are queued as expectations and checked by a monitor on the falling edge.
module tb_dm_hart_ctrl;

    localparam logic [6:0] A_DATA0 = 7'h04;
    localparam logic [6:0] A_DMC   = 7'h10;
    localparam logic [6:0] A_DMS   = 7'h11;
    localparam logic [6:0] A_ACS   = 7'h16;
    localparam logic [6:0] A_CMD   = 7'h17;
    localparam logic [6:0] A_AUTO  = 7'h18;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        dmi_en_i = 1'b0;
    logic        dmi_wr_i = 1'b0;
    logic [6:0]  dmi_addr_i = '0;
    logic [31:0] dmi_wdata_i = '0;
    logic [31:0] dmi_rdata_o;
    logic        dbg_haltreq_o;
    logic        dbg_resumereq_o;
    logic        core_resumeack_i = 1'b0;
    logic        core_running_i = 1'b0;
    logic        core_halted_i = 1'b0;
    logic        dbg_ar_en_o;
    logic        dbg_ar_wr_o;
    logic [15:0] dbg_ar_ad_o;
    logic [31:0] dbg_ar_do_o;
    logic [31:0] dbg_ar_di_i = '0;

    dm_hart_ctrl dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .dmi_en_i         (dmi_en_i),
        .dmi_wr_i         (dmi_wr_i),
        .dmi_addr_i       (dmi_addr_i),
        .dmi_wdata_i      (dmi_wdata_i),
        .dmi_rdata_o      (dmi_rdata_o),
        .dbg_haltreq_o    (dbg_haltreq_o),
        .dbg_resumereq_o  (dbg_resumereq_o),
        .core_resumeack_i (core_resumeack_i),
        .core_running_i   (core_running_i),
        .core_halted_i    (core_halted_i),
        .dbg_ar_en_o      (dbg_ar_en_o),
        .dbg_ar_wr_o      (dbg_ar_wr_o),
        .dbg_ar_ad_o      (dbg_ar_ad_o),
        .dbg_ar_do_o      (dbg_ar_do_o),
        .dbg_ar_di_i      (dbg_ar_di_i)
    );

    always #5 clk_i = ~clk_i;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          ar_pulses = 0;
    int          ar_expected = 0;
    int          rd_cnt = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_exp_q[$];
    int          rd_tag_q[$];
    logic [48:0] ar_exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        dmi_en_i    = 1'b1;
        dmi_wr_i    = 1'b1;
        dmi_addr_i  = a;
        dmi_wdata_i = d;
        step();
        dmi_en_i = 1'b0;
        dmi_wr_i = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] a, input logic [31:0] exp);
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(rd_cnt);
        rd_cnt++;
        dmi_en_i   = 1'b1;
        dmi_wr_i   = 1'b0;
        dmi_addr_i = a;
        step();
        dmi_en_i = 1'b0;
    endtask

    task automatic expect_ar(input logic w, input logic [15:0] ad, input logic [31:0] d);
        ar_exp_q.push_back({w, ad, d});
        ar_expected++;
    endtask

    // Monitor: read data appears one cycle after a read strobe; every ar_en
    // cycle must match the oldest queued access.
    always @(negedge clk_i) begin
        logic [31:0] e;
        logic [48:0] ea;
        int          tag;
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", dmi_rdata_o, 32'hxxxx_xxxx);
            end else begin
                e   = rd_exp_q.pop_front();
                tag = rd_tag_q.pop_front();
                check($sformatf("rd#%0d", tag), dmi_rdata_o, e);
            end
        end
        rd_pend = reset_ni && dmi_en_i && !dmi_wr_i;
        if (dbg_ar_en_o) begin
            ar_pulses++;
            if (ar_exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL ar_unexpected: pulse with ad=0x%04h, expected no access", dbg_ar_ad_o);
            end else begin
                ea = ar_exp_q.pop_front();
                check($sformatf("ar_ctl#%0d", ar_pulses), {15'd0, dbg_ar_wr_o, dbg_ar_ad_o},
                      {15'd0, ea[48:32]});
                check($sformatf("ar_do#%0d", ar_pulses), dbg_ar_do_o, ea[31:0]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        dbg_ar_di_i = 32'h1234_5678;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_haltreq", {31'd0, dbg_haltreq_o}, 32'd0);
        check("rst_resumereq", {31'd0, dbg_resumereq_o}, 32'd0);
        check("rst_ar_en", {31'd0, dbg_ar_en_o}, 32'd0);
        check("rst_rdata", dmi_rdata_o, 32'd0);
        reset_ni = 1'b1;
        step();
        dmi_read(A_DMC, 32'h0);
        dmi_read(A_ACS, 32'h1);
        dmi_read(A_DATA0, 32'h0);

        // Halt request and dmstatus
        dmi_write(A_DMC, 32'h8000_0001);
        check("haltreq_set", {31'd0, dbg_haltreq_o}, 32'd1);
        core_halted_i = 1'b1;
        dmi_read(A_DMS, 32'h0000_0382);
        dmi_read(A_DMC, 32'h8000_0001);

        // Resume handshake
        dmi_write(A_DMC, 32'h4000_0001);
        check("resumereq_on", {31'd0, dbg_resumereq_o}, 32'd1);
        check("haltreq_clr", {31'd0, dbg_haltreq_o}, 32'd0);
        step();
        step();
        check("resumereq_hold", {31'd0, dbg_resumereq_o}, 32'd1);
        core_resumeack_i = 1'b1;
        core_halted_i    = 1'b0;
        core_running_i   = 1'b1;
        step();
        check("resumereq_off", {31'd0, dbg_resumereq_o}, 32'd0);
        dmi_read(A_DMS, 32'h0003_0C82);
        dmi_read(A_DMC, 32'h0000_0001);
        core_resumeack_i = 1'b0;
        step();
        dmi_write(A_DMC, 32'h4000_0001);
        check("resume_ignored", {31'd0, dbg_resumereq_o}, 32'd0);

        // Command while running
        dmi_write(A_CMD, 32'h0023_0001);
        dmi_read(A_ACS, 32'h0000_0401);
        dmi_write(A_CMD, 32'h0023_0001);
        dmi_read(A_ACS, 32'h0000_0401);
        dmi_write(A_ACS, 32'h0000_0700);
        dmi_read(A_ACS, 32'h0000_0001);

        // Halt again; resumeack stays sticky
        core_running_i = 1'b0;
        core_halted_i  = 1'b1;
        dmi_write(A_DMC, 32'h8000_0001);
        dmi_read(A_DMS, 32'h0003_0382);

        // Abstract write of GPR 1 with busy timing
        dmi_write(A_DATA0, 32'hDEAD_BEEF);
        expect_ar(1'b1, 16'h0001, 32'hDEAD_BEEF);
        dmi_write(A_CMD, 32'h0023_0001);
        check("ar_en_n1", {31'd0, dbg_ar_en_o}, 32'd1);
        dmi_read(A_ACS, 32'h0000_1001);
        check("ar_en_n2", {31'd0, dbg_ar_en_o}, 32'd0);
        dmi_read(A_ACS, 32'h0000_1001);
        dmi_read(A_ACS, 32'h0000_0001);
        dmi_read(A_DATA0, 32'hDEAD_BEEF);

        // Abstract read of CSR 0x300
        expect_ar(1'b0, 16'h0300, 32'hDEAD_BEEF);
        dmi_write(A_CMD, 32'h0022_0300);
        step();
        step();
        dmi_read(A_DATA0, 32'h1234_5678);
        dmi_read(A_ACS, 32'h0000_0001);

        // Back-to-back command writes
        expect_ar(1'b1, 16'h0005, 32'h1234_5678);
        dmi_write(A_CMD, 32'h0023_0005);
        dmi_write(A_CMD, 32'h0023_0006);
        dmi_read(A_ACS, 32'h0000_1101);
        dmi_read(A_ACS, 32'h0000_0101);
        dmi_write(A_CMD, 32'h0023_0009);
        dmi_write(A_ACS, 32'h0000_0100);
        dmi_read(A_ACS, 32'h0000_0001);

        // Unsupported commands and transfer=0
        dmi_write(A_CMD, 32'h0122_0000);
        dmi_read(A_ACS, 32'h0000_0201);
        dmi_write(A_ACS, 32'h0000_0700);
        dmi_write(A_CMD, 32'h0033_0001);
        dmi_read(A_ACS, 32'h0000_0201);
        dmi_write(A_ACS, 32'h0000_0200);
        dmi_write(A_CMD, 32'h0020_0000);
        dmi_read(A_ACS, 32'h0000_1001);
        dmi_read(A_ACS, 32'h0000_0001);

        // data0 write while busy is dropped
        expect_ar(1'b1, 16'h0007, 32'h1234_5678);
        dmi_write(A_CMD, 32'h0023_0007);
        dmi_write(A_DATA0, 32'h1111_1111);
        dmi_read(A_ACS, 32'h0000_1101);
        dmi_write(A_ACS, 32'h0000_0700);
        dmi_read(A_DATA0, 32'h1234_5678);
        dmi_read(A_ACS, 32'h0000_0001);

        // Unmapped and abstractauto addresses
        dmi_write(7'h05, 32'hFFFF_FFFF);
        dmi_read(7'h05, 32'h0);
        dmi_read(7'h20, 32'h0);
        dmi_read(A_AUTO, 32'h0);

        // dmactive=0 holds everything at reset
        dmi_write(A_DMC, 32'h8000_0000);
        check("inactive_haltreq", {31'd0, dbg_haltreq_o}, 32'd0);
        step();
        dmi_read(A_DATA0, 32'h0);
        dmi_write(A_DATA0, 32'hCAFE_F00D);
        dmi_read(A_DATA0, 32'h0);
        dmi_read(A_DMC, 32'h0);
        dmi_write(A_CMD, 32'h0023_0001);
        check("inactive_ar_en", {31'd0, dbg_ar_en_o}, 32'd0);

        // Reset during A_XFER aborts the access
        dmi_write(A_DMC, 32'h0000_0001);
        dbg_ar_di_i = 32'hA5A5_A5A5;
        dmi_write(A_CMD, 32'h0022_0300);
        check("xfer_before_rst", {31'd0, dbg_ar_en_o}, 32'd1);
        reset_ni = 1'b0;
        #1;
        check("xfer_rst_ar_en", {31'd0, dbg_ar_en_o}, 32'd0);
        step();
        step();
        reset_ni = 1'b1;
        step();
        dmi_write(A_DMC, 32'h0000_0001);
        dmi_read(A_DATA0, 32'h0);
        dmi_read(A_ACS, 32'h0000_0001);
        dmi_read(A_DMC, 32'h0000_0001);
        step();
        step();

        check("ar_pulse_count", ar_pulses, ar_expected);
        check("rd_queue_empty", rd_exp_q.size(), 32'd0);
        check("ar_queue_empty", ar_exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
